mcpu_decrypt_table: RTL
=======================

# mcpu_decrypt_table

Runtime-programmable opcode/data decryption stage for the main CPU ROM path. It sits between the program ROM/SDRAM read data and the Z80 data-in mux. It applies a per-fetch bit permutation plus XOR mask selected from a key table. The table is indexed by fetch type (M1) and two address bits. The table is streamed in through the ROM-download port, so one core build serves every key variant.

## Interface
Parameters:
- DW, 8: decrypted data width; must be 8 or 16.
- AW, 16: CPU address width.
- SEL_HI, 13: address bit used as table index bit 1.
- SEL_LO, 2: address bit used as table index bit 0.

Ports:
- clk_sys  in  1  core clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  8  0 = bypass; any nonzero value = table decrypt.
- in_valid  in  1  fetch strobe; data_in, addr and m1 are sampled when high.
- data_in  in  DW  encrypted ROM data.
- addr  in  AW  fetch address.
- m1  in  1  1 = opcode fetch, 0 = data/operand read.
- out_valid  out  1  data_out is valid.
- data_out  out  DW  decrypted data.
- key_start  in  1  one-cycle pulse; begins a key stream.
- key_we  in  1  one-cycle strobe; key_data is the next stream byte.
- key_data  in  8  key stream byte.
- key_busy  out  1  high from key_start until the commit completes.

## Operation
- Table: 8 entries, indexed by idx = {m1, addr[SEL_HI], addr[SEL_LO]}.
  - Each entry holds DW source indices perm[i] (log2(DW) bits) and a DW-bit mask.
- Decrypt: data_out[i] = data_in[perm[i]] ^ mask[i]. With mode == 0, data_out = data_in.
- Two copies of the table:
  - The active table feeds decrypt.
  - The shadow table receives the key stream.
  - Reset sets both to identity: perm[i]=i, mask=0.
- Stream layout, per entry 0..7 in order:
  - DW bytes of perm, perm[0] first; only the low log2(DW) bits are used.
  - Then DW/8 bytes of mask, little-endian.
  - Total length L = 8*(DW + DW/8) bytes: 72 for DW=8, 144 for DW=16.
- Key FSM:
  - IDLE: key_start → LOAD with pointer = 0. key_we is ignored.
  - LOAD: each key_we writes shadow[pointer] and increments the pointer. The write of byte L-1 → COMMIT.
  - LOAD, key_start again: pointer returns to 0. Already-written shadow bytes are kept.
  - COMMIT: one cycle; active ← shadow → IDLE.
  - key_busy = (state != IDLE).
- Simultaneous events:
  - key_start and key_we in the same cycle: the start wins and the byte is dropped.
  - key_we during COMMIT: ignored.
  - A fetch in the COMMIT cycle uses the old active table. Fetches from the next cycle use the new table.
  - A fetch during LOAD always uses the active table, so a partial stream never affects decryption.
- A mode change takes effect on the next sampled fetch. It does not touch either table.

## Timing
- Reset (reset_n low at an edge):
  - out_valid=0, data_out=0, key_busy=0, FSM=IDLE, pointer=0.
  - Both tables set to identity.
  - Reset during LOAD abandons the stream.
- Decrypt latency with DECRYPT_OUT_REG_EN (see Configuration): 1 cycle.
  - out_valid is high for exactly the cycle after in_valid.
  - data_out holds its last value until the next in_valid.
  - Back-to-back in_valid is supported every cycle.
- Key load: the commit is visible to fetches 2 cycles after the final key_we. key_busy falls in that same cycle.
- No backpressure: the decrypt path and the key path are always ready.

## Configuration
- DECRYPT_OUT_REG_EN defined:
  - data_out and out_valid are registered; latency 1 as above.
- DECRYPT_OUT_REG_EN undefined:
  - Decrypt path is purely combinational from data_in, addr, m1, mode and the active table.
  - out_valid = in_valid and latency is 0. data_out does not hold between strobes.
  - The key FSM is unchanged.

## Test plan
- Reset, then mode=1, fetch data_in=0xA5 at any addr/m1 → data_out=0xA5 (identity table).
- Stream a DW=8 key where entry 5 (m1=1, addr[13]=0, addr[2]=1) has perm={7,6,5,4,3,2,1,0} and mask=0x81. Fetch 0x01, m1=1, addr=0x0004 → data_out=0x01 (reversal gives 0x80, XOR 0x81). Same fetch with m1=0 → 0x01 via the identity entry 1.
- mode=0 with the loaded key, fetch 0x3C → 0x3C. mode=1 on the very next fetch → the table applies.
- Issue 40 key_we bytes, then fetch → old table used and key_busy=1. Issue key_start and a full 72-byte stream → key_busy falls 2 cycles after the last byte, and a fetch in the COMMIT cycle still sees the old table.
- Assert reset_n low mid-stream, then fetch 0xC3 with mode=1 → data_out=0xC3 and key_busy=0. key_we with no key_start → no effect.
- DW=16 build, 144-byte stream with mask=0x1234 on entry 0, perm identity. Fetch 0x0000, m1=0, addr=0 → data_out=0x1234.

Source files
------------

// File: rtl/mcpu_decrypt_table.sv
// Runtime-programmable opcode/data decryption: per-fetch bit permutation plus XOR mask
// chosen from an 8-entry key table streamed in over the ROM-download port.
// Build option: define DECRYPT_OUT_REG_EN to register data_out/out_valid (latency 1);
// otherwise the decrypt path is combinational (latency 0).
module mcpu_decrypt_table #(
    parameter int DW     = 8,
    parameter int AW     = 16,
    parameter int SEL_HI = 13,
    parameter int SEL_LO = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [7:0]    mode,
    input  logic          in_valid,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] addr,
    input  logic          m1,
    output logic          out_valid,
    output logic [DW-1:0] data_out,
    input  logic          key_start,
    input  logic          key_we,
    input  logic [7:0]    key_data,
    output logic          key_busy
);

    localparam int PW = $clog2(DW);
    localparam int MB = DW / 8;
    localparam int EB = DW + MB;
    localparam int BW = $clog2(EB);
    localparam logic [BW-1:0] LAST_BYTE = BW'(EB - 1);

    typedef logic [DW-1:0][PW-1:0] perm_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } key_state_t;

    key_state_t            state_r;
    logic [2:0]            entry_r;
    logic [BW-1:0]         byte_r;
    logic                  key_busy_r;
    logic [7:0][DW-1:0][PW-1:0] act_perm_r;
    logic [7:0][DW-1:0][PW-1:0] shd_perm_r;
    logic [7:0][DW-1:0]    act_mask_r;
    logic [7:0][DW-1:0]    shd_mask_r;

    logic [2:0]            idx_s;
    logic [DW-1:0]         dec_s;
    logic                  unused_addr_s;

    function automatic perm_t identity_perm();
        perm_t p;
        for (int i = 0; i < DW; i++) begin
            p[i] = PW'(i);
        end
        return p;
    endfunction

    function automatic logic [DW-1:0] decrypt(input logic [DW-1:0] d, input perm_t p,
                                              input logic [DW-1:0] m);
        logic [DW-1:0] r;
        r = {DW{1'b0}};
        for (int i = 0; i < DW; i++) begin
            r[i] = d[p[i]] ^ m[i];
        end
        return r;
    endfunction

    assign idx_s         = {m1, addr[SEL_HI], addr[SEL_LO]};
    assign unused_addr_s = ^addr;
    assign key_busy      = key_busy_r;

    // Key stream FSM: fills the shadow table entry by entry, then copies it to the active table
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            entry_r    <= 3'd0;
            byte_r     <= {BW{1'b0}};
            key_busy_r <= 1'b0;
            act_mask_r <= {(8*DW){1'b0}};
            shd_mask_r <= {(8*DW){1'b0}};
            for (int e = 0; e < 8; e++) begin
                act_perm_r[e] <= identity_perm();
                shd_perm_r[e] <= identity_perm();
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (key_start) begin
                        state_r    <= ST_LOAD;
                        entry_r    <= 3'd0;
                        byte_r     <= {BW{1'b0}};
                        key_busy_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // A restart rewinds the pointer but keeps bytes already in the shadow table
                    if (key_start) begin
                        entry_r <= 3'd0;
                        byte_r  <= {BW{1'b0}};
                    end else if (key_we) begin
                        for (int i = 0; i < DW; i++) begin
                            if (byte_r == BW'(i)) begin
                                shd_perm_r[entry_r][i] <= key_data[PW-1:0];
                            end
                        end
                        for (int k = 0; k < MB; k++) begin
                            if (byte_r == BW'(DW + k)) begin
                                shd_mask_r[entry_r][8*k +: 8] <= key_data;
                            end
                        end
                        if (entry_r == 3'd7 && byte_r == LAST_BYTE) begin
                            state_r <= ST_COMMIT;
                            entry_r <= 3'd0;
                            byte_r  <= {BW{1'b0}};
                        end else if (byte_r == LAST_BYTE) begin
                            entry_r <= entry_r + 3'd1;
                            byte_r  <= {BW{1'b0}};
                        end else begin
                            byte_r  <= byte_r + BW'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    act_perm_r <= shd_perm_r;
                    act_mask_r <= shd_mask_r;
                    state_r    <= ST_IDLE;
                    key_busy_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    key_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Decrypt datapath; mode 0 passes data straight through
    always_comb begin
        dec_s = data_in;
        if (mode != 8'd0) begin
            dec_s = decrypt(data_in, act_perm_r[idx_s], act_mask_r[idx_s]);
        end else begin
            dec_s = data_in;
        end
    end

`ifdef DECRYPT_OUT_REG_EN
    logic          out_valid_r;
    logic [DW-1:0] data_out_r;

    // Output register: data_out holds its value between fetch strobes
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            data_out_r  <= {DW{1'b0}};
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                data_out_r <= dec_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
`else
    assign out_valid = in_valid;
    assign data_out  = dec_s;
`endif

endmodule
